reg_scoreboard: RTL
===================

# reg_scoreboard

Register-occupancy scheduler between the decode and data-fetch stages of the core pipeline. Each architectural GPR and RFLAGS has a pending-write counter. The block decides every cycle whether the decoded micro-op may be issued, and counts writebacks out. On a redirect (exe/wb branch) it blocks issue until every in-flight write has drained.

## Interface
Parameters:
- NREG, 17: tracked registers; indices 0..15 are GPRs in `GPR_*` numbering, index 16 is RFLAGS.
- CNT_W, 2: pending-write counter width; maximum in-flight writes per register is 2^CNT_W-1.

Ports:
- clk  in  1  core clock (bus.clk).
- reset  in  1  asynchronous, active-low reset.
- chk_valid  in  1  decoded micro-op is presented for issue.
- chk_src_mask  in  NREG  registers read by the micro-op.
- chk_dst_mask  in  NREG  registers written by the micro-op. RDAX sets bits RAX and RDX; STACK sets RSP.
- issue_ok  out  1  combinational; the micro-op may issue this cycle.
- iss_fire  in  1  issuer accepted the micro-op. Legal only when issue_ok=1. The dst mask is taken from chk_dst_mask.
- wb_valid  in  1  writeback stage retires a micro-op.
- wb_dst_mask  in  NREG  registers retired by that writeback.
- flush  in  1  pipeline redirect (wb_branch | exe_branch).
- busy_mask  out  NREG  registered; bit i=1 when counter[i]!=0.
- drained  out  1  registered; all counters are zero.
- err  out  1  sticky; an underflow, overflow or illegal fire was detected.

## Operation
- State per register: cnt[i], CNT_W bits.
- FSM states:
  - RUN: normal operation.
  - DRAIN: redirect in progress.
- Transitions:
  - RUN→DRAIN: on flush=1.
  - DRAIN→RUN: in the first cycle where all cnt=0 and flush=0.
  - flush while in DRAIN: stays in DRAIN.
- issue_ok = chk_valid & state==RUN & no RAW & no saturation.
  - RAW: some i with chk_src_mask[i] & cnt[i]!=0.
  - Saturation: some i with chk_dst_mask[i] & cnt[i]==max.
  - WAW does not stall below saturation; writeback is in order.
- Counter update each clock, for every i:
  - Apply +1 if iss_fire & chk_dst_mask[i].
  - Apply −1 if wb_valid & wb_dst_mask[i].
  - Both in the same cycle: cnt unchanged.
- Errors. err is set, and is cleared only by reset, when any of these occur:
  - −1 applied at cnt=0: counter holds at 0.
  - +1 applied at max (without a matching −1): counter holds at max.
  - iss_fire while issue_ok=0: the issue is ignored; no counter changes.
- flush does not clear counters. Writebacks of older micro-ops keep arriving and are counted out. iss_fire is ignored while in DRAIN or while flush=1.
- busy_mask and drained are derived from the registered counters.

## Timing
- Reset values (asynchronous, when reset=0): all cnt=0, state=RUN, busy_mask=0, drained=1, err=0. issue_ok then follows its inputs combinationally (0 whenever chk_valid=0).
- issue_ok is combinational from chk_* and registered state; there is no input-to-state path within a cycle.
- Issue at edge N: busy_mask and RAW blocking are visible from cycle N+1.
- Writeback at edge N: cnt decrements at N. A dependent micro-op checked in cycle N (before the edge) still stalls, unless the bypass below is enabled. issue_ok is first 1 in cycle N+1.
- flush sampled at edge N: issue_ok=0 from cycle N+1.
- Once in DRAIN with all cnt=0 and flush=0: RUN is entered at the next edge, and issue_ok may be 1 the cycle after that edge.
- Reset asserted mid-DRAIN: the block returns immediately to RUN with all counters zero.

## Configuration
- SCOREBOARD_WB_BYPASS_EN.
  - Defined: the RAW and saturation checks use the counter value after the current cycle's wb_valid/wb_dst_mask decrement. A register with cnt=1 that is being written back this cycle does not block.
  - Undefined: the checks use the registered cnt only, adding one cycle of stall per dependency.
  - The DRAIN exit condition is unaffected either way.

## Test plan
- Reset, then chk_valid=1, src=RAX, dst=RBX → issue_ok=1. After iss_fire: busy_mask = bit RBX only; drained=0.
- Issue a micro-op with dst=RAX, then present a micro-op with src=RAX:
  - issue_ok=0 until wb_valid with wb_dst_mask=RAX.
  - Without bypass: issue_ok=1 the cycle after the writeback.
  - With SCOREBOARD_WB_BYPASS_EN: issue_ok=1 in the writeback cycle.
- Three fires with dst=RCX (CNT_W=2) → cnt=3 and a fourth dst=RCX micro-op sees issue_ok=0. One writeback → cnt=2 and issue_ok=1.
- Two in-flight writes (RDX, RSP), then pulse flush:
  - issue_ok=0 and the micro-op is not accepted.
  - Deliver the two writebacks → drained=1.
  - The next edge returns to RUN; the following cycle issue_ok=1.
- Same-cycle iss_fire dst=R8 and wb_valid dst=R8 with cnt[R8]=1 → cnt stays 1 and busy_mask[R8]=1.
- wb_valid dst=R9 with cnt[R9]=0 → err=1 and cnt[R9]=0. err stays 1 until reset=0 is asserted, after which err=0 asynchronously.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue-check, writeback and status bundle for the register scoreboard
interface reg_scoreboard_if #(
  parameter int NREG = 17
);
  logic            chk_valid;
  logic [NREG-1:0] chk_src_mask;
  logic [NREG-1:0] chk_dst_mask;
  logic            issue_ok;
  logic            iss_fire;
  logic            wb_valid;
  logic [NREG-1:0] wb_dst_mask;
  logic            flush;
  logic [NREG-1:0] busy_mask;
  logic            drained;
  logic            err;

  modport master (
    output chk_valid, chk_src_mask, chk_dst_mask, iss_fire,
    output wb_valid, wb_dst_mask, flush,
    input  issue_ok, busy_mask, drained, err
  );

  modport slave (
    input  chk_valid, chk_src_mask, chk_dst_mask, iss_fire,
    input  wb_valid, wb_dst_mask, flush,
    output issue_ok, busy_mask, drained, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write scoreboard gating decode-to-fetch issue, drains on redirect
// Optional: SCOREBOARD_WB_BYPASS_EN lets the issue check see this cycle's writeback decrement.
module reg_scoreboard #(
  parameter int NREG  = 17,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  reg_scoreboard_if.slave   bus
);
  typedef enum logic {ST_RUN, ST_DRAIN} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q   [NREG];
  logic [CNT_W-1:0] cnt_d   [NREG];
  logic [CNT_W-1:0] chk_cnt [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            drained_q, drained_d;
  logic            err_q, err_d;

  logic [NREG-1:0] wb_dec;
  logic [NREG-1:0] iss_inc;
  logic            raw_hit, sat_hit, issue_ok;
  logic            fire_ok, fire_bad;
  logic            ovf, unf;

  assign wb_dec = {NREG{bus.wb_valid}} & bus.wb_dst_mask;

  // Counter view used by the issue check; the bypass looks through this cycle's writeback.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      chk_cnt[i] = cnt_q[i];
`ifdef SCOREBOARD_WB_BYPASS_EN
      if (wb_dec[i] && cnt_q[i] != '0) chk_cnt[i] = cnt_q[i] - CNT_W'(1);
`endif
    end
  end

  always_comb begin
    raw_hit = 1'b0;
    sat_hit = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.chk_src_mask[i] && chk_cnt[i] != '0)   raw_hit = 1'b1;
      if (bus.chk_dst_mask[i] && chk_cnt[i] == CNT_MAX) sat_hit = 1'b1;
    end
    issue_ok = bus.chk_valid && (state_q == ST_RUN) && !raw_hit && !sat_hit;
  end

  // A redirect in the same cycle swallows an otherwise legal fire without flagging it.
  assign fire_ok  = bus.iss_fire && issue_ok && !bus.flush;
  assign fire_bad = bus.iss_fire && !issue_ok;
  assign iss_inc  = {NREG{fire_ok}} & bus.chk_dst_mask;

  always_comb begin
    ovf = 1'b0;
    unf = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (iss_inc[i] && !wb_dec[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (wb_dec[i] && !iss_inc[i]) begin
        if (cnt_q[i] == '0) unf = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) busy_d[i] = (cnt_d[i] != '0);
    drained_d = ~|busy_d;
    err_d     = err_q | fire_bad | ovf | unf;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      busy_q    <= '0;
      drained_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN:   if (bus.flush) state_q <= ST_DRAIN;
        // drained_q mirrors the registered counters, so exit waits for them to read zero.
        ST_DRAIN: if (!bus.flush && drained_q) state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      busy_q    <= busy_d;
      drained_q <= drained_d;
      err_q     <= err_d;
    end
  end

  assign bus.issue_ok  = issue_ok;
  assign bus.busy_mask = busy_q;
  assign bus.drained   = drained_q;
  assign bus.err       = err_q;
endmodule
